// File: rtl/clarvi_part_sequencer.sv
// clarvi_part_sequencer
//   Splits each decoded instruction into NUM_PARTS slices of PART_WIDTH bits and
//   issues them on consecutive cycles, in ascending order or descending order
//   (reverse_order). For each issued part it forwards the rs1/rs2 operand slices
//   from the youngest matching later stage, or from the register file. It also
//   raises the decode-hold and load-dependency stalls.
//
// Optional feature macro:
//   CLARVI_NARROW_SKIP_EN - 32-bit (*_32) ops issue a single part (narrow_issue).
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   stage_invalid          no valid instruction in decode
//   stall_stage            decode held this cycle; includes the load-dependency stall
//   reverse_order          issue parts from high to low
//   is_narrow              instruction is a 32-bit op
//   rs1/rs2, rs*_used      source register ids and read enables
//   rs*_fetched            register-file slice for the current part
//   fwd_*                  per-stage forwarding info; index 0 = EX, NUM_FWD-1 = WB
//   mem_address_error      EX load faults, which suppresses the load stall
//   part_index             part issued this cycle
//   first_part, last_part  issued part is first / last in its sequence
//   narrow_issue           single-part narrow issue
//   rs1_value, rs2_value   forwarded operand slices
//   stall_for_decode       hold fetch because more parts follow
//   stall_for_load_dep     an operand waits on the EX load result
//   All outputs are combinational from the part counter and the inputs.

module clarvi_part_sequencer #(
  parameter int unsigned PART_WIDTH = 32,
  parameter int unsigned NUM_PARTS  = 2,
  parameter int unsigned NUM_FWD    = 3,
  localparam int unsigned PW        = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               stage_invalid,
  input  logic                               stall_stage,
  input  logic                               reverse_order,
  input  logic                               is_narrow,
  input  logic [4:0]                         rs1,
  input  logic [4:0]                         rs2,
  input  logic                               rs1_used,
  input  logic                               rs2_used,
  input  logic [PART_WIDTH-1:0]              rs1_fetched,
  input  logic [PART_WIDTH-1:0]              rs2_fetched,
  input  logic [NUM_FWD-1:0]                 fwd_valid,
  input  logic [NUM_FWD-1:0]                 fwd_enable_wb,
  input  logic [NUM_FWD-1:0]                 fwd_is_load,
  input  logic [NUM_FWD-1:0][4:0]            fwd_rd,
  input  logic [NUM_FWD-1:0][PW-1:0]         fwd_part,
  input  logic [NUM_FWD-1:0][PART_WIDTH-1:0] fwd_value,
  input  logic                               mem_address_error,
  output logic [PW-1:0]                      part_index,
  output logic                               first_part,
  output logic                               last_part,
  output logic                               narrow_issue,
  output logic [PART_WIDTH-1:0]              rs1_value,
  output logic [PART_WIDTH-1:0]              rs2_value,
  output logic                               stall_for_decode,
  output logic                               stall_for_load_dep
);

  localparam logic [PW-1:0] LAST_WIDE = PW'(NUM_PARTS - 1);

  logic [PW-1:0] count;
  logic [PW-1:0] len_m1;
  logic [NUM_FWD-1:0] hit1;
  logic [NUM_FWD-1:0] hit2;

  // Narrow ops collapse to one part only when the skip feature is built in.
`ifdef CLARVI_NARROW_SKIP_EN
  assign narrow_issue = is_narrow && (NUM_PARTS > 1);
`else
  logic unused_is_narrow;
  assign unused_is_narrow = is_narrow;
  assign narrow_issue     = 1'b0;
`endif

  assign len_m1     = narrow_issue ? '0 : LAST_WIDE;
  assign part_index = reverse_order ? PW'(len_m1 - count) : count;
  assign first_part = (count == '0);
  assign last_part  = (count == len_m1);

  assign stall_for_decode = !stage_invalid && !last_part;

  // Part counter; a stalled stage holds it, an invalid stage or last part clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!stall_stage) begin
      if (stage_invalid || last_part) begin
        count <= '0;
      end else begin
        count <= PW'(count + PW'(1));
      end
    end
  end

  // Per-stage hits; an EX-stage load has no result yet so it never forwards.
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int i = 0; i < int'(NUM_FWD); i++) begin
      if (fwd_valid[i] && fwd_enable_wb[i] && (fwd_part[i] == part_index) &&
          !((i == 0) && fwd_is_load[0])) begin
        hit1[i] = rs1_used && (fwd_rd[i] == rs1);
        hit2[i] = rs2_used && (fwd_rd[i] == rs2);
      end
    end
  end

  // Operand select: walk oldest to youngest so the lowest-index hit wins.
  always_comb begin
    rs1_value = rs1_fetched;
    rs2_value = rs2_fetched;
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (hit1[i]) rs1_value = fwd_value[i];
      if (hit2[i]) rs2_value = fwd_value[i];
    end
  end

  assign stall_for_load_dep = !stage_invalid && fwd_valid[0] && fwd_is_load[0] &&
                              !mem_address_error &&
                              ((rs1_used && (rs1 == fwd_rd[0])) ||
                               (rs2_used && (rs2 == fwd_rd[0]))) &&
                              (fwd_part[0] == part_index);

endmodule

// File: tb/tb_clarvi_part_sequencer.sv
module tb_clarvi_part_sequencer;

  logic clock = 1'b0;
  logic reset;
  logic stage_invalid, stall_stage, reverse_order, is_narrow;
  logic [4:0] rs1, rs2;
  logic rs1_used, rs2_used;
  logic [31:0] rs1_fetched, rs2_fetched;
  logic [2:0] fwd_valid, fwd_enable_wb, fwd_is_load;
  logic [2:0][4:0] fwd_rd;
  logic [2:0][0:0] fwd_part;
  logic [2:0][1:0] fwd_part4;
  logic [2:0][31:0] fwd_value;
  logic mem_address_error;

  // NUM_PARTS=2 instance outputs
  logic [0:0] pi2;
  logic first2, last2, narrow2, sfd2, sld2;
  logic [31:0] rv1_2, rv2_2;
  // NUM_PARTS=4 instance outputs
  logic [1:0] pi4;
  logic first4, last4, narrow4, sfd4, sld4;
  logic [31:0] rv1_4, rv2_4;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  clarvi_part_sequencer #(.PART_WIDTH(32), .NUM_PARTS(2), .NUM_FWD(3)) dut2 (
    .clock(clock), .reset(reset), .stage_invalid(stage_invalid), .stall_stage(stall_stage),
    .reverse_order(reverse_order), .is_narrow(is_narrow), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rs1_fetched(rs1_fetched), .rs2_fetched(rs2_fetched),
    .fwd_valid(fwd_valid), .fwd_enable_wb(fwd_enable_wb), .fwd_is_load(fwd_is_load),
    .fwd_rd(fwd_rd), .fwd_part(fwd_part), .fwd_value(fwd_value),
    .mem_address_error(mem_address_error), .part_index(pi2), .first_part(first2),
    .last_part(last2), .narrow_issue(narrow2), .rs1_value(rv1_2), .rs2_value(rv2_2),
    .stall_for_decode(sfd2), .stall_for_load_dep(sld2));

  clarvi_part_sequencer #(.PART_WIDTH(32), .NUM_PARTS(4), .NUM_FWD(3)) dut4 (
    .clock(clock), .reset(reset), .stage_invalid(stage_invalid), .stall_stage(stall_stage),
    .reverse_order(reverse_order), .is_narrow(is_narrow), .rs1(rs1), .rs2(rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rs1_fetched(rs1_fetched), .rs2_fetched(rs2_fetched),
    .fwd_valid(fwd_valid), .fwd_enable_wb(fwd_enable_wb), .fwd_is_load(fwd_is_load),
    .fwd_rd(fwd_rd), .fwd_part(fwd_part4), .fwd_value(fwd_value),
    .mem_address_error(mem_address_error), .part_index(pi4), .first_part(first4),
    .last_part(last4), .narrow_issue(narrow4), .rs1_value(rv1_4), .rs2_value(rv2_4),
    .stall_for_decode(sfd4), .stall_for_load_dep(sld4));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    stage_invalid = 1'b1; stall_stage = 1'b0; reverse_order = 1'b0; is_narrow = 1'b0;
    rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    rs1_fetched = 32'hDEAD_0001; rs2_fetched = 32'hDEAD_0002;
    fwd_valid = '0; fwd_enable_wb = '0; fwd_is_load = '0;
    fwd_rd = '0; fwd_part = '0; fwd_part4 = '0; fwd_value = '0;
    mem_address_error = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #3;
    checks++; if (pi2 !== 1'd0) begin errors++; $display("FAIL reset pi2: got %0d want 0", pi2); end
    checks++; if (first2 !== 1'b1) begin errors++; $display("FAIL reset first2: got %0b want 1", first2); end
    checks++; if (sfd2 !== 1'b0) begin errors++; $display("FAIL reset sfd2: got %0b want 0", sfd2); end
    checks++; if (sld2 !== 1'b0) begin errors++; $display("FAIL reset sld2: got %0b want 0", sld2); end
    checks++; if (sfd4 !== 1'b0 || first4 !== 1'b1) begin errors++; $display("FAIL reset dut4: sfd=%0b first=%0b want 0/1", sfd4, first4); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_two_part();
    clear_inputs();
    do_reset();
    stage_invalid = 1'b0;
    #1;
    checks++; if (pi2 !== 1'd0 || sfd2 !== 1'b1 || first2 !== 1'b1 || last2 !== 1'b0) begin
      errors++; $display("FAIL two_part p0: idx=%0d sfd=%0b first=%0b last=%0b want 0/1/1/0", pi2, sfd2, first2, last2); end
    step();
    checks++; if (pi2 !== 1'd1 || sfd2 !== 1'b0 || first2 !== 1'b0 || last2 !== 1'b1) begin
      errors++; $display("FAIL two_part p1: idx=%0d sfd=%0b first=%0b last=%0b want 1/0/0/1", pi2, sfd2, first2, last2); end
    step();
    checks++; if (pi2 !== 1'd0 || first2 !== 1'b1) begin
      errors++; $display("FAIL two_part wrap: idx=%0d first=%0b want 0/1", pi2, first2); end
    stage_invalid = 1'b1;
    step();
  endtask

  task automatic test_reverse4();
    logic [1:0] exp_idx [7];
    logic       exp_last [7];
    logic       exp_stall [7];
    clear_inputs();
    do_reset();
    stage_invalid = 1'b0;
    reverse_order = 1'b1;
    exp_idx   = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd3};
    exp_last  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_stall = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 7; k++) begin
      stall_stage = exp_stall[k];
      #1;
      checks++; if (pi4 !== exp_idx[k] || last4 !== exp_last[k]) begin
        errors++; $display("FAIL reverse4 step%0d: idx=%0d last=%0b want %0d/%0b", k, pi4, last4, exp_idx[k], exp_last[k]); end
      step();
    end
    stall_stage = 1'b0;
    stage_invalid = 1'b1;
    step();
  endtask

  task automatic test_forward();
    clear_inputs();
    do_reset();
    stage_invalid = 1'b0;
    step();  // dut2 now at part 1
    rs1 = 5'd5; rs1_used = 1'b1; rs1_fetched = 32'h0000_DEAD;
    fwd_valid = 3'b011; fwd_enable_wb = 3'b011;
    fwd_rd[0] = 5'd5; fwd_part[0] = 1'd1; fwd_value[0] = 32'hAAAA_0000;
    fwd_rd[1] = 5'd5; fwd_part[1] = 1'd1; fwd_value[1] = 32'h0000_1111;
    #1;
    checks++; if (rv1_2 !== 32'hAAAA_0000) begin errors++; $display("FAIL fwd_ex: got %h want aaaa0000", rv1_2); end
    fwd_part[0] = 1'd0;
    #1;
    checks++; if (rv1_2 !== 32'h0000_1111) begin errors++; $display("FAIL fwd_ma: got %h want 00001111", rv1_2); end
    fwd_part[0] = 1'd1; fwd_is_load[0] = 1'b1;
    #1;
    checks++; if (rv1_2 !== 32'h0000_1111 || sld2 !== 1'b1) begin
      errors++; $display("FAIL fwd_ex_load: val=%h sld=%0b want 00001111/1", rv1_2, sld2); end
    fwd_is_load[0] = 1'b0; fwd_valid[1] = 1'b0; fwd_enable_wb[0] = 1'b0;
    #1;
    checks++; if (rv1_2 !== 32'h0000_DEAD) begin errors++; $display("FAIL fwd_none: got %h want 0000dead", rv1_2); end
    fwd_enable_wb[0] = 1'b1; rs1_used = 1'b0;
    #1;
    checks++; if (rv1_2 !== 32'h0000_DEAD) begin errors++; $display("FAIL fwd_unused: got %h want 0000dead", rv1_2); end
    stage_invalid = 1'b1;
    step();
  endtask

  task automatic test_load_dep();
    clear_inputs();
    do_reset();
    stage_invalid = 1'b0;
    rs2 = 5'd7; rs2_used = 1'b1;
    fwd_valid[0] = 1'b1; fwd_enable_wb[0] = 1'b1; fwd_is_load[0] = 1'b1;
    fwd_rd[0] = 5'd7; fwd_part[0] = 1'd0;
    #1;
    checks++; if (sld2 !== 1'b1) begin errors++; $display("FAIL load_dep: got %0b want 1", sld2); end
    mem_address_error = 1'b1;
    #1;
    checks++; if (sld2 !== 1'b0) begin errors++; $display("FAIL load_dep_mae: got %0b want 0", sld2); end
    mem_address_error = 1'b0; fwd_part[0] = 1'd1;
    #1;
    checks++; if (sld2 !== 1'b0) begin errors++; $display("FAIL load_dep_part: got %0b want 0", sld2); end
    fwd_part[0] = 1'd0; rs2_used = 1'b0;
    #1;
    checks++; if (sld2 !== 1'b0) begin errors++; $display("FAIL load_dep_unused: got %0b want 0", sld2); end
    rs2_used = 1'b1; stage_invalid = 1'b1;
    #1;
    checks++; if (sld2 !== 1'b0) begin errors++; $display("FAIL load_dep_invalid: got %0b want 0", sld2); end
    step();
  endtask

  task automatic test_narrow();
    clear_inputs();
    do_reset();
    stage_invalid = 1'b0;
    is_narrow = 1'b1;
    #1;
`ifdef CLARVI_NARROW_SKIP_EN
    checks++; if (narrow2 !== 1'b1 || sfd2 !== 1'b0 || last2 !== 1'b1 || pi2 !== 1'd0) begin
      errors++; $display("FAIL narrow_p0: nar=%0b sfd=%0b last=%0b idx=%0d want 1/0/1/0", narrow2, sfd2, last2, pi2); end
    step();
    checks++; if (pi2 !== 1'd0 || first2 !== 1'b1) begin
      errors++; $display("FAIL narrow_next: idx=%0d first=%0b want 0/1", pi2, first2); end
`else
    checks++; if (narrow2 !== 1'b0 || sfd2 !== 1'b1 || last2 !== 1'b0 || pi2 !== 1'd0) begin
      errors++; $display("FAIL narrow_p0: nar=%0b sfd=%0b last=%0b idx=%0d want 0/1/0/0", narrow2, sfd2, last2, pi2); end
    step();
    checks++; if (pi2 !== 1'd1 || last2 !== 1'b1) begin
      errors++; $display("FAIL narrow_p1: idx=%0d last=%0b want 1/1", pi2, last2); end
`endif
    stage_invalid = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    do_reset();
    stage_invalid = 1'b0;
    step();
    checks++; if (pi2 !== 1'd1) begin errors++; $display("FAIL reset_mid pre: idx=%0d want 1", pi2); end
    reset = 1'b1;
    #1;
    checks++; if (pi2 !== 1'd0 || first2 !== 1'b1) begin
      errors++; $display("FAIL reset_mid async: idx=%0d first=%0b want 0/1", pi2, first2); end
    reset = 1'b0;
    step();
    checks++; if (pi2 !== 1'd1) begin errors++; $display("FAIL reset_mid resume: idx=%0d want 1", pi2); end
    stage_invalid = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    do_reset();
    stage_invalid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (pi2 !== 1'(k % 2)) begin
        errors++; $display("FAIL back_to_back %0d: idx=%0d want %0d", k, pi2, k % 2); end
      step();
    end
    stage_invalid = 1'b1;
    step();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_two_part();
    test_reverse4();
    test_forward();
    test_load_dep();
    test_narrow();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clarvi_part_sequencer.md
# clarvi_part_sequencer

Parametrised multi-part issue sequencer and per-part operand forwarder for the clarvi decode stage. Splits each instruction into `NUM_PARTS` slices of `PART_WIDTH` bits, issued over consecutive cycles, in ascending or descending order per instruction. For each issued part it selects rs1/rs2 operands from the register file or from any of `NUM_FWD` later stages, matching register and part index. It also raises the decode-hold and load-dependency stalls. Sits between the decode function logic and the DE/EX pipeline register.

## Interface
- `PART_WIDTH`, 32, datapath slice width in bits
- `NUM_PARTS`, 2, slices per full-width instruction (≥1); `PW = max(1, $clog2(NUM_PARTS))`
- `NUM_FWD`, 3, forwarding stages; index 0 = EX (youngest), `NUM_FWD-1` = WB (oldest)
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `stage_invalid`  in  1  no valid instruction in decode
- `stall_stage`  in  1  decode stage held this cycle (global stall)
- `reverse_order`  in  1  issue parts high-to-low (SRL/SRA 64-bit, SLT, SLTU)
- `is_narrow`  in  1  instruction is a 32-bit (`*_32`) op
- `rs1`, `rs2`  in  5 each  source register ids
- `rs1_used`, `rs2_used`  in  1 each  source register read (already false for x0)
- `rs1_fetched`, `rs2_fetched`  in  `PART_WIDTH` each  register-file slice for current part
- `fwd_valid`, `fwd_enable_wb`, `fwd_is_load`  in  `NUM_FWD` each  per-stage valid / writes rd / is a load
- `fwd_rd`  in  `NUM_FWD`×5  per-stage destination
- `fwd_part`  in  `NUM_FWD`×`PW`  per-stage part index
- `fwd_value`  in  `NUM_FWD`×`PART_WIDTH`  per-stage result slice
- `mem_address_error`  in  1  EX load faults (suppresses load stall)
- `part_index`  out  `PW`  part issued this cycle
- `first_part`, `last_part`  out  1 each  issued part is first / last in sequence
- `narrow_issue`  out  1  single-part narrow issue (downstream sign-extends)
- `rs1_value`, `rs2_value`  out  `PART_WIDTH` each  forwarded operands
- `stall_for_decode`  out  1  hold fetch: more parts follow
- `stall_for_load_dep`  out  1  operand awaits EX load result

## Operation
- State: counter `count[PW-1:0]`; effective length `len = narrow_issue ? 1 : NUM_PARTS`.
- `part_index = reverse_order ? len-1-count : count`; `first_part = (count==0)`; `last_part = (count==len-1)`.
- Counter update, only when `!stall_stage`: `stage_invalid` → 0; else `last_part` → 0; else `count+1`.
- `stall_for_decode = !stage_invalid && !last_part`.
- Forwarding per source, lowest index wins: stage i hits when `fwd_valid[i] && fwd_enable_wb[i] && fwd_rd[i]==rsN && fwd_part[i]==part_index && !(i==0 && fwd_is_load[0])`. No hit → `rsN_fetched`. Unused source (`rsN_used=0`) passes `rsN_fetched`.
- `stall_for_load_dep = !stage_invalid && fwd_valid[0] && fwd_is_load[0] && !mem_address_error && ((rs1_used && rs1==fwd_rd[0]) || (rs2_used && rs2==fwd_rd[0])) && fwd_part[0]==part_index`.
- Counter does not advance on load-dependency stall; `stall_stage` includes it externally.
- `NUM_PARTS==1`: count constant 0, `last_part` always 1, `stall_for_decode` always 0.

## Timing
- All outputs combinational from `count` and inputs; forwarding adds zero latency.
- Instruction occupies `len` unstalled cycles in decode; throughput 1 part/cycle.
- `reset` asserted: `count` = 0 immediately (async). With `stage_invalid=1`, all stall outputs = 0 and `first_part=1`.
- Reset mid-sequence: partial instruction is abandoned; the next valid instruction restarts at count 0.
- `stage_invalid` with `stall_stage=1`: count holds.
- `reverse_order` and `is_narrow` must stay stable for the whole sequence; this holds because fetch is held by `stall_for_decode`.

## Configuration
- `CLARVI_NARROW_SKIP_EN` defined: `narrow_issue = is_narrow && NUM_PARTS>1`, so narrow ops issue one part (`part_index`=0).
- Undefined: `narrow_issue` tied 0; narrow ops issue all `NUM_PARTS` parts like wide ops.

## Test plan
- NUM_PARTS=2, ADD valid, no stalls → `part_index` 0 then 1; `stall_for_decode` 1 then 0; count returns to 0.
- NUM_PARTS=4, `reverse_order=1` → `part_index` 3,2,1,0; `last_part` only on 0; `stall_stage` held 2 cycles mid-sequence → index frozen.
- EX stage rd=5 part=1 value 0xAAAA0000, MA rd=5 part=1 value 0x1111, decode rs1=5 at part 1 → `rs1_value`=0xAAAA0000; EX part=0 instead → 0x1111.
- EX load rd=7 part 0, decode rs2=7 `rs2_used` at part 0 → `stall_for_load_dep`=1; same with `mem_address_error`=1 → 0.
- With `CLARVI_NARROW_SKIP_EN`, `is_narrow=1`, NUM_PARTS=2 → one cycle, `narrow_issue`=1, `stall_for_decode`=0; without the macro → two cycles.
- `reset` pulsed while count=1 of 2 → count 0 asynchronously; next instruction starts at `part_index`=0.
